// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit feeding the {hi, lo} writeback.
// Shift-add multiply, restoring divide, with a sign fixup pass for signed ops.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int HILO_IDX = 34
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic              reg_write,
  output logic [5:0]        wb_dest,
  output logic [2*XLEN-1:0] prod
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic            is_idle;
  logic            in_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div0;

  logic [XLEN:0]   msum;
  logic [PW-1:0]   mul_nxt;
  logic [PW-1:0]   dsh;
  logic [XLEN:0]   dtry;
  logic [PW-1:0]   div_nxt;
  logic [XLEN-1:0] q_raw;
  logic [XLEN-1:0] r_raw;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign is_idle = (state_q == S_IDLE);
  assign in_sgn  = ~op[0];
  assign a_neg   = in_sgn & src_a[XLEN-1];
  assign b_neg   = in_sgn & src_b[XLEN-1];
  assign abs_a   = a_neg ? (~src_a + 1'b1) : src_a;
  assign abs_b   = b_neg ? (~src_b + 1'b1) : src_b;
  assign div0    = op[1] & (src_b == '0);

  // Multiplier sits in acc[XLEN-1:0]; carry of the add lands in the MSB.
  assign msum    = {1'b0, acc_q[PW-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {msum, acc_q[XLEN-1:1]};

  // Remainder can briefly need XLEN+1 bits after the shift.
  assign dsh     = {acc_q[PW-2:0], 1'b0};
  assign dtry    = {acc_q[PW-1], dsh[PW-1:XLEN]} - {1'b0, opnd_q};
  assign div_nxt = dtry[XLEN] ? dsh
                 : {dtry[XLEN-1:0], dsh[XLEN-1:1], 1'b1};

  assign q_raw = acc_q[XLEN-1:0];
  assign r_raw = acc_q[PW-1:XLEN];
  assign q_fix = negq_q ? (~q_raw + 1'b1) : q_raw;
  assign r_fix = negr_q ? (~r_raw + 1'b1) : r_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    prod_d  = prod_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          cnt_d  = '0;
          negq_d = a_neg ^ b_neg;
          negr_d = op[1] & a_neg;
          if (div0) begin
            opnd_d  = abs_b;
            acc_d   = {src_a, {XLEN{1'b1}}};
            state_d = S_DONE;
          end else if (op[1]) begin
            opnd_d  = abs_b;
            acc_d   = {{XLEN{1'b0}}, abs_a};
            state_d = S_CALC;
          end else begin
            opnd_d  = abs_a;
            acc_d   = {{XLEN{1'b0}}, abs_b};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[1] ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = S_FIXUP;
          end
        end
      end
      S_FIXUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            acc_d = {r_fix, q_fix};
          end else if (negq_q) begin
            acc_d = ~acc_q + 1'b1;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          prod_d = acc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      prod_q  <= prod_d;
    end
  end

  // The new result is visible during DONE; a flush there keeps the old one.
  assign done      = (state_q == S_DONE) & ~flush;
  assign reg_write = done;
  assign busy      = ~is_idle;
  assign stall     = busy | (start & is_idle);
  assign wb_dest   = 6'(HILO_IDX);
  assign prod      = done ? acc_q : prod_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit.
// Expected results come from plain 64-bit integer arithmetic.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic        reg_write;
  logic [5:0]  wb_dest;
  logic [63:0] prod;

  muldiv_unit dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .reg_write (reg_write),
    .wb_dest   (wb_dest),
    .prod      (prod)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  always @(posedge clock) cyc++;

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = '0;
    case (o)
      2'd0: p = sa * sbv;
      2'd1: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none",
                   cyc);
        end else begin
          e = sb.pop_front();
          chk("prod", prod, e.prod);
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("reg_write", 64'(reg_write), 64'd1);
          chk("wb_dest", 64'(wb_dest), 64'd34);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_wait: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push,
                       input logic [63:0] expv, output int t);
    exp_t e;
    wait_idle();
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    t     = cyc;
    if (push) begin
      e.prod = expv;
      e.due  = t + ((o[1] && b == 32'd0) ? 1 : 34);
      sb.push_back(e);
    end
    #3;
    chk("stall_on_start", 64'(stall), 64'd1);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    int n;
    int sel;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] held;

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_wb_dest", 64'(wb_dest), 64'd34);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    issue(2'd0, 32'hFFFF_FFFD, 32'd5, 1, 64'hFFFF_FFFF_FFFF_FFF1, t);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, t);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'h0000_0000_0000_0001, t);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, t);
    issue(2'd3, 32'd100, 32'd7, 1, 64'h0000_0002_0000_000E, t);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000, t);
    issue(2'd3, 32'h0000_1234, 32'd0, 1, 64'h0000_1234_FFFF_FFFF, t);
    @(posedge clock);
    #1;
    chk("div0_busy_T+2", 64'(busy), 64'd0);

    issue(2'd0, 32'd123, 32'd456, 1, 64'd56088, t);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    op    = 2'd1;
    src_a = 32'hFFFF_FFFF;
    src_b = 32'd2;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;

    wait_idle();
    held = prod;
    issue(2'd3, 32'd1000, 32'd3, 0, 64'd0, t);
    repeat (19) begin
      @(posedge clock);
      #1;
    end
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    repeat (40) begin
      @(posedge clock);
      #1;
    end
    chk("flush_prod_held", prod, held);

    issue(2'd0, 32'd77, 32'd88, 0, 64'd0, t);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_prod", prod, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    issue(2'd0, 32'd6, 32'd7, 1, 64'd42, t);

    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      issue(ro, ra, rb, 1, model(ro, ra, rb), t);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the 64-bit {hi, lo} result consumed by the register file's $hi/$lo write path. It sits beside the EX stage, accepts one operation at a time, and computes it over 32 iteration cycles. On completion it presents the result on `prod` with destination index 34, the special writeback index that loads $hi/$lo together. While it is busy it raises a stall request to the pipeline.

## Interface
- `XLEN`, 32: operand width; `prod` is 2*XLEN.
- `HILO_IDX`, 34: writeback destination index that selects the {hi, lo} pair write.

- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `start`  in  1  request a new operation; sampled only in IDLE
- `op`  in  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- `src_a`  in  32  multiplicand / dividend (rs)
- `src_b`  in  32  multiplier / divisor (rt)
- `flush`  in  1  synchronous abort of the in-flight operation
- `busy`  out  1  high from the cycle after accept until the cycle `done` is high, inclusive
- `stall`  out  1  equals `busy | (start & idle)`; holds the next hi/lo consumer in ID
- `done`  out  1  one-cycle pulse; `prod` is valid in this cycle
- `reg_write`  out  1  equals `done`; drives the writeback RegWrite for this result
- `wb_dest`  out  6  constant `HILO_IDX`
- `prod`  out  64  {hi, lo}; holds its value until the next `done`

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE with `start`=1 latches `op`, |a| and |b|, and the result signs, then clears `cnt`:
  - Signed ops take the absolute value; unsigned ops pass the operands through.
  - A DIV/DIVU with `src_b`==0 goes directly to DONE. Otherwise the next state is CALC.
- CALC runs 32 cycles, with `cnt` counting 0..31.
  - Multiply uses shift-add: a 64-bit accumulator adds |a| into the upper half when the multiplier LSB is 1, then shifts right by 1.
  - Divide uses restoring division: shift {rem, quot} left by 1, trial-subtract |b| from rem, keep the result if it is non-negative and set quot LSB=1.
  - When `cnt`==31 the next state is FIXUP.
- FIXUP applies sign correction for MULT/DIV, in 64-bit two's complement:
  - MULT: negate the 64-bit product if sign(a)^sign(b).
  - DIV: quotient is negated if sign(a)^sign(b). Remainder takes the sign of the dividend. Quotient truncates toward zero.
  - DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This falls out of the unsigned-magnitude arithmetic and needs no special case.
  - Unsigned ops pass through unchanged. Next state is DONE.
- DONE registers `prod` and pulses `done`/`reg_write` for one cycle, then returns to IDLE.
  - Multiply: `prod` = {product[63:32], product[31:0]}.
  - Divide: `prod` = {remainder, quotient}.
  - Divide by zero: `prod` = {src_a, 32'hFFFF_FFFF}.
- `start` is ignored outside IDLE. `start` in the DONE cycle is also ignored; it must be re-presented in the next cycle.
- `flush` in CALC, FIXUP or DONE returns the unit to IDLE on the next edge. No `done` is generated and `prod` is unchanged. `flush` has priority over state advance, including DONE: a flush in the DONE cycle suppresses the `prod` update and the pulse. `flush` together with `start` in IDLE means no accept.
- Reset (asynchronous, active-low) forces the following immediately, including mid-operation: state=IDLE, `cnt`=0, `prod`=0, `busy`=0, `done`=0, `reg_write`=0, all internal operand registers=0.

## Timing
- Accept in cycle T (IDLE, `start`=1). CALC runs T+1..T+32, FIXUP is T+33, DONE is T+34. `done`=1 during T+34 only.
- Latency is 34 cycles from accept to result. Back-to-back throughput is one op per 35 cycles, since the next accept is at T+35.
- Divide by zero: DONE at T+1, `done` during T+1.
- `busy`=1 from T+1 through the `done` cycle inclusive, and 0 in IDLE.
- `prod` changes only on the edge that enters DONE and is stable from that cycle onward.
- Reset values: `busy`=0, `stall`=0, `done`=0, `reg_write`=0, `prod`=0, `wb_dest`=34.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5, accept at T: `done` only at T+34, `prod`=0xFFFFFFFF_FFFFFFF1, `reg_write`=1, `wb_dest`=34.
- MULTU a=b=0xFFFFFFFF: `prod`=0xFFFFFFFE_00000001. Also MULT with the same operands: `prod`=0x00000000_00000001.
- Divide signs and overflow:
  - DIV a=0xFFFFFFF9 (-7), b=2: `prod`={0xFFFFFFFF, 0xFFFFFFFD}.
  - DIVU a=100, b=7: `prod`={2, 14}.
  - DIV 0x80000000 / 0xFFFFFFFF: `prod`={0, 0x80000000}.
- DIVU a=0x1234, b=0, accept at T: `done` at T+1, `prod`={0x00001234, 0xFFFFFFFF}, `busy` low at T+2.
- Start while busy:
  - Pulse `start` with new operands at T+10: ignored, and the original result still arrives at T+34.
  - `flush` at T+20: `busy`=0 from T+21, no `done` pulse, `prod` keeps its prior value.
- Assert `reset` low at T+15 mid-CALC: `busy`, `done` and `prod` read 0 immediately. After release, a new MULT 6*7 gives `prod`=42 at its T'+34.
